// File: rtl/regfile_mp_scoreboard_if.sv
// Bus bundle for the multi-port register file: read ports, both writeback
// ports, load-issue scoreboard and the debug read path.
interface regfile_mp_scoreboard_if #(
  parameter int REG_WIDTH      = 8,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_DIR_WIDTH  = 3,
  parameter int NUM_READ       = 2
);
  logic [NUM_READ*REG_DIR_WIDTH-1:0] readr;
  logic [NUM_READ*REG_WIDTH-1:0]     readd;
  logic [NUM_READ-1:0]               read_busy;
  logic                              we_a;
  logic [REG_DIR_WIDTH-1:0]          wa_a;
  logic [REG_WIDTH-1:0]              wd_a;
  logic                              we_b;
  logic [REG_DIR_WIDTH-1:0]          wa_b;
  logic [REG_WIDTH-1:0]              wd_b;
  logic                              issue_valid;
  logic [REG_DIR_WIDTH-1:0]          issue_reg;
  logic [REG_FILE_DEPTH-1:0]         busy_vec;
  logic [REG_DIR_WIDTH-1:0]          dbg_sel;
  logic [REG_WIDTH-1:0]              dbg_data;

  modport master (
    output readr, we_a, wa_a, wd_a, we_b, wa_b, wd_b, issue_valid, issue_reg, dbg_sel,
    input  readd, read_busy, busy_vec, dbg_data
  );

  modport slave (
    input  readr, we_a, wa_a, wd_a, we_b, wa_b, wd_b, issue_valid, issue_reg, dbg_sel,
    output readd, read_busy, busy_vec, dbg_data
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Register file with ALU/load write ports, write-through read bypass,
// per-register load busy scoreboard and a registered debug read port.
module regfile_mp_scoreboard #(
  parameter int REG_WIDTH      = 8,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_DIR_WIDTH  = 3,
  parameter int NUM_READ       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_mp_scoreboard_if.slave rf
);

  logic [REG_WIDTH-1:0]      regs_q [REG_FILE_DEPTH];
  logic [REG_WIDTH-1:0]      regs_d [REG_FILE_DEPTH];
  logic [REG_FILE_DEPTH-1:0] busy_q, busy_d;
  logic [REG_WIDTH-1:0]      dbg_q, dbg_d;

  // Nonzero and inside the implemented depth; everything else reads 0 and never writes.
  function automatic logic valid_addr(input logic [REG_DIR_WIDTH-1:0] a);
    return (a != '0) && (int'(a) < REG_FILE_DEPTH);
  endfunction

  function automatic logic [REG_WIDTH-1:0] read_path(input logic [REG_DIR_WIDTH-1:0] a);
    logic [REG_WIDTH-1:0] v;
    v = '0;
    if (valid_addr(a)) begin
      if (rf.we_b && rf.wa_b == a)      v = rf.wd_b;
      else if (rf.we_a && rf.wa_a == a) v = rf.wd_a;
      else                              v = regs_q[a];
    end
    return v;
  endfunction

  // Port B is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (rf.we_a && valid_addr(rf.wa_a)) regs_d[rf.wa_a] = rf.wd_a;
    if (rf.we_b && valid_addr(rf.wa_b)) regs_d[rf.wa_b] = rf.wd_b;
    regs_d[0] = '0;
  end

  // Issue after clear: a new load to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (rf.we_b && valid_addr(rf.wa_b))               busy_d[rf.wa_b]      = 1'b0;
    if (rf.issue_valid && valid_addr(rf.issue_reg))   busy_d[rf.issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    dbg_d = read_path(rf.dbg_sel);
  end

  always_comb begin
    rf.readd     = '0;
    rf.read_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rf.readd[k*REG_WIDTH +: REG_WIDTH] = read_path(rf.readr[k*REG_DIR_WIDTH +: REG_DIR_WIDTH]);
      // A load landing this cycle is forwarded, so its target need not stall.
      rf.read_busy[k] = valid_addr(rf.readr[k*REG_DIR_WIDTH +: REG_DIR_WIDTH])
                      && busy_q[rf.readr[k*REG_DIR_WIDTH +: REG_DIR_WIDTH]]
                      && !(rf.we_b && rf.wa_b == rf.readr[k*REG_DIR_WIDTH +: REG_DIR_WIDTH]);
    end
  end

  assign rf.busy_vec = busy_q;
  assign rf.dbg_data = dbg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_FILE_DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomised and directed bench for regfile_mp_scoreboard against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_mp_scoreboard;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_scoreboard_if #(.REG_WIDTH(W), .REG_FILE_DEPTH(D), .REG_DIR_WIDTH(AW), .NUM_READ(NR)) rf_if();

  regfile_mp_scoreboard #(.REG_WIDTH(W), .REG_FILE_DEPTH(D), .REG_DIR_WIDTH(AW), .NUM_READ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_regs [D];
  logic [D-1:0] m_busy;
  logic [W-1:0] m_dbg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    rf_if.readr       = '0;
    rf_if.we_a        = 1'b0;
    rf_if.wa_a        = '0;
    rf_if.wd_a        = '0;
    rf_if.we_b        = 1'b0;
    rf_if.wa_b        = '0;
    rf_if.wd_b        = '0;
    rf_if.issue_valid = 1'b0;
    rf_if.issue_reg   = '0;
    rf_if.dbg_sel     = '0;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < D; i++) m_regs[i] = '0;
    m_busy = '0;
    m_dbg  = '0;
  endfunction

  // What a reader sees this cycle: zero register, then load data, then ALU data, then storage.
  function automatic logic [W-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (rf_if.we_b && int'(rf_if.wa_b) == a) return rf_if.wd_b;
    if (rf_if.we_a && int'(rf_if.wa_a) == a) return rf_if.wd_a;
    return m_regs[a];
  endfunction

  function automatic logic m_stall(input int a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(rf_if.we_b && int'(rf_if.wa_b) == a);
  endfunction

  task automatic check_comb();
    int a;
    for (int k = 0; k < NR; k++) begin
      a = int'(rf_if.readr[k*AW +: AW]);
      check_eq($sformatf("readd%0d", k), rf_if.readd[k*W +: W], m_read(a));
      check_eq($sformatf("read_busy%0d", k), rf_if.read_busy[k], m_stall(a));
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step();
    logic [W-1:0] nregs [D];
    logic [D-1:0] nbusy;
    logic [W-1:0] ndbg;
    #1;
    check_comb();
    nregs = m_regs;
    if (rf_if.we_a && rf_if.wa_a != 0) nregs[rf_if.wa_a] = rf_if.wd_a;
    if (rf_if.we_b && rf_if.wa_b != 0) nregs[rf_if.wa_b] = rf_if.wd_b;
    nbusy = m_busy;
    if (rf_if.we_b && rf_if.wa_b != 0)               nbusy[rf_if.wa_b] = 1'b0;
    if (rf_if.issue_valid && rf_if.issue_reg != 0)   nbusy[rf_if.issue_reg] = 1'b1;
    ndbg = m_read(int'(rf_if.dbg_sel));
    @(posedge clk);
    #1;
    m_regs = nregs;
    m_busy = nbusy;
    m_dbg  = ndbg;
    check_eq("busy_vec", rf_if.busy_vec, m_busy);
    check_eq("dbg_data", rf_if.dbg_data, m_dbg);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    m_reset();
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_busy", rf_if.busy_vec, 8'h00);
    check_eq("rst_dbg", rf_if.dbg_data, 8'h00);

    // Load R1..R7 and leave R3 busy before the mid-cycle reset.
    for (int i = 1; i < D; i++) begin
      set_idle();
      rf_if.we_a = 1'b1;
      rf_if.wa_a = AW'(i);
      rf_if.wd_a = W'(i * 8'h11);
      if (i == 7) begin
        rf_if.issue_valid = 1'b1;
        rf_if.issue_reg   = 3'd3;
      end
      step();
    end
    set_idle();
    rf_if.readr   = {3'd2, 3'd1};
    rf_if.dbg_sel = 3'd5;
    step();
    check_eq("pre_rst_r1", rf_if.readd[7:0], 8'h11);
    check_eq("pre_rst_dbg", rf_if.dbg_data, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_rd0", rf_if.readd[7:0], 8'h00);
    check_eq("async_rst_rd1", rf_if.readd[15:8], 8'h00);
    check_eq("async_rst_busy", rf_if.busy_vec, 8'h00);
    check_eq("async_rst_dbg", rf_if.dbg_data, 8'h00);
    m_reset();
    rf_if.we_a        = 1'b1;
    rf_if.wa_a        = 3'd1;
    rf_if.wd_a        = 8'h55;
    rf_if.issue_valid = 1'b1;
    rf_if.issue_reg   = 3'd2;
    @(posedge clk);
    #1;
    set_idle();
    rf_if.readr = {3'd2, 3'd1};
    #1;
    check_eq("rst_write_drop", rf_if.readd[7:0], 8'h00);
    check_eq("rst_issue_drop", rf_if.busy_vec, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero register ignores writes.
    set_idle();
    rf_if.we_a = 1'b1;
    rf_if.wa_a = 3'd0;
    rf_if.wd_a = 8'hFF;
    #1;
    check_eq("zero_rd", rf_if.readd[7:0], 8'h00);
    step();
    check_eq("zero_dbg", rf_if.dbg_data, 8'h00);

    // Dual write to R3: port B wins, both in bypass and in storage.
    set_idle();
    rf_if.we_a = 1'b1; rf_if.wa_a = 3'd3; rf_if.wd_a = 8'h12;
    rf_if.we_b = 1'b1; rf_if.wa_b = 3'd3; rf_if.wd_b = 8'h34;
    rf_if.readr = {3'd0, 3'd3};
    #1;
    check_eq("dual_bypass", rf_if.readd[7:0], 8'h34);
    step();
    set_idle();
    rf_if.readr = {3'd5, 3'd3};
    rf_if.we_a = 1'b1; rf_if.wa_a = 3'd5; rf_if.wd_a = 8'h56;
    #1;
    check_eq("dual_stored", rf_if.readd[7:0], 8'h34);
    check_eq("a_bypass", rf_if.readd[15:8], 8'h56);
    step();

    // Scoreboard stall on R4 until its load returns.
    set_idle();
    rf_if.issue_valid = 1'b1; rf_if.issue_reg = 3'd4;
    step();
    check_eq("sb_set", rf_if.busy_vec[4], 1'b1);
    set_idle();
    rf_if.readr = {3'd4, 3'd0};
    #1;
    check_eq("sb_stall", rf_if.read_busy[1], 1'b1);
    step();
    set_idle();
    rf_if.readr = {3'd4, 3'd0};
    rf_if.we_b = 1'b1; rf_if.wa_b = 3'd4; rf_if.wd_b = 8'h9A;
    #1;
    check_eq("sb_fwd_nostall", rf_if.read_busy[1], 1'b0);
    check_eq("sb_fwd_data", rf_if.readd[15:8], 8'h9A);
    step();
    check_eq("sb_clear", rf_if.busy_vec[4], 1'b0);

    // Set and clear of R2 together: stays busy, data still written.
    set_idle();
    rf_if.issue_valid = 1'b1; rf_if.issue_reg = 3'd2;
    step();
    set_idle();
    rf_if.issue_valid = 1'b1; rf_if.issue_reg = 3'd2;
    rf_if.we_b = 1'b1; rf_if.wa_b = 3'd2; rf_if.wd_b = 8'h01;
    step();
    check_eq("collide_busy", rf_if.busy_vec[2], 1'b1);
    set_idle();
    rf_if.readr = {3'd0, 3'd2};
    #1;
    check_eq("collide_data", rf_if.readd[7:0], 8'h01);
    step();

    // Debug port is one cycle behind dbg_sel.
    set_idle();
    rf_if.we_a = 1'b1; rf_if.wa_a = 3'd6; rf_if.wd_a = 8'hC3;
    rf_if.dbg_sel = 3'd6;
    step();
    check_eq("dbg_lat", rf_if.dbg_data, 8'hC3);
    set_idle();
    rf_if.dbg_sel = 3'd1;
    #1;
    check_eq("dbg_hold", rf_if.dbg_data, 8'hC3);
    step();

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_eq("rnd_rst_busy", rf_if.busy_vec, 8'h00);
        check_eq("rnd_rst_dbg", rf_if.dbg_data, 8'h00);
        rst = 1'b0;
        step();
      end
      rf_if.readr       = AW'($urandom) | (AW'($urandom) << AW);
      rf_if.readr       = {AW'($urandom), AW'($urandom)};
      rf_if.we_a        = ($urandom_range(0, 2) == 0);
      rf_if.wa_a        = AW'($urandom);
      rf_if.wd_a        = W'($urandom);
      rf_if.we_b        = ($urandom_range(0, 2) == 0);
      rf_if.wa_b        = AW'($urandom);
      rf_if.wd_b        = W'($urandom);
      rf_if.issue_valid = ($urandom_range(0, 2) == 0);
      rf_if.issue_reg   = AW'($urandom);
      rf_if.dbg_sel     = AW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor register file for the MIPS datapath: generic depth, width and number of read ports.
- Two write ports: A for ALU writeback, B for load writeback.
- Per-register busy scoreboard for in-flight loads, so the hazard unit can stall dependent reads.
- One-cycle registered debug read port for the FPGA display path.
- Register 0 is hardwired to zero.

Parameters:
REG_WIDTH, 8, data width of each register
REG_FILE_DEPTH, 8, number of registers (2**REG_DIR_WIDTH)
REG_DIR_WIDTH, 3, register address width
NUM_READ, 2, number of combinational read ports (1..4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
readr  input  NUM_READ*REG_DIR_WIDTH  packed read addresses; port k = bits [k*REG_DIR_WIDTH +: REG_DIR_WIDTH]
readd  output  NUM_READ*REG_WIDTH  packed read data; port k = bits [k*REG_WIDTH +: REG_WIDTH]
read_busy  output  NUM_READ  port k address is pending a load; caller must stall
we_a  input  1  write enable, port A (ALU)
wa_a  input  REG_DIR_WIDTH  write address A
wd_a  input  REG_WIDTH  write data A
we_b  input  1  write enable, port B (load); also clears busy
wa_b  input  REG_DIR_WIDTH  write address B
wd_b  input  REG_WIDTH  write data B
issue_valid  input  1  a load targeting issue_reg is issued this cycle
issue_reg  input  REG_DIR_WIDTH  destination register of the issued load
busy_vec  output  REG_FILE_DEPTH  scoreboard bits; bit 0 is always 0
dbg_sel  input  REG_DIR_WIDTH  debug read address
dbg_data  output  REG_WIDTH  registered debug read data

Behaviour:
- Reset (async, rst=1): every register = 0, busy_vec = 0, dbg_data = 0, takes effect immediately regardless of clk. A write or issue in the same cycle as reset is discarded.
- Writes on posedge clk:
  - Port A writes RegFile[wa_a] when we_a=1; port B writes RegFile[wa_b] when we_b=1.
  - Writes to address 0 are ignored.
  - Both ports enabled to the same nonzero address: port B wins.
- Reads, per port k, combinational, zero latency, priority order:
  - address 0 -> 0;
  - we_b && wa_b==addr -> wd_b;
  - we_a && wa_a==addr -> wd_a;
  - else RegFile[addr].
  - Bypass is gated by the write enables: a disabled port never forwards.
- Scoreboard on posedge clk:
  - issue_valid && issue_reg!=0 sets busy[issue_reg].
  - we_b && wa_b!=0 clears busy[wa_b].
  - Set and clear of the same register in one cycle: set wins (newer load).
  - Port A writes never change busy.
  - busy[0] is held at 0.
- read_busy[k] = busy[readr_k] && !(we_b && wa_b==readr_k). The load data is being forwarded in that cycle, so no stall. Address 0 is never busy.
- Debug port: at each posedge, dbg_data <= normal read-path value for dbg_sel, including bypass. It therefore equals the register's post-edge content. Latency 1 cycle.
- Out-of-range addresses (when REG_FILE_DEPTH < 2**REG_DIR_WIDTH): read 0, writes and issues ignored.
- Rising edge of rst mid-operation clears everything, including pending busy bits. A load writeback arriving after reset still writes data normally; busy is already 0 and stays 0.

Test Plan:
- Reset: load R1..R7 = 0x11..0x77, assert rst between clock edges -> all readd = 0, busy_vec = 0, dbg_data = 0 immediately, without a clock edge.
- Zero register: we_a=1, wa_a=0, wd_a=0xFF, then readr0=0 -> readd0 = 0; dbg_sel=0 -> dbg_data = 0.
- Dual write and bypass: same cycle, we_a(R3, 0x12) and we_b(R3, 0x34) with readr0=3 -> readd0 = 0x34 that cycle; after the edge RegFile[3] = 0x34. we_a(R5, 0x56) only -> readd1 = 0x56 combinationally in the same cycle.
- Scoreboard stall: issue_valid with R4 -> busy_vec[4]=1; next cycle readr1=4 -> read_busy[1]=1; cycle with we_b(R4, 0x9A) -> read_busy[1]=0 and readd1 = 0x9A; after that edge busy_vec[4]=0.
- Set/clear collision: busy[2]=1; same cycle issue_valid(R2) and we_b(R2, 0x01) -> busy[2] stays 1, RegFile[2] = 0x01.
- Debug latency: we_a(R6, 0xC3) with dbg_sel=6 -> dbg_data = 0xC3 after that edge (1 cycle). Change dbg_sel to 1 -> dbg_data updates only at the next edge.
